telemetry_tx_scheduler: RTL
===========================

Name: telemetry_tx_scheduler

Overview:
- Shares the single cellphone UART transmitter among four telemetry sources: 0 heart rate, 1 speed/RPM, 2 pitch angle, 3 ADC sample.
- Collects requests from a periodic tick and from on-demand pulses.
- Grants sources round-robin and frames each grant as a 5-byte packet: SYNC, ID, DATA_HI, DATA_LO, CSUM.
- Sequences the packet byte by byte into the UART using its transmit/is_transmitting handshake.

Parameters:
- PERIOD_CYCLES, 5000000, periodic tick interval in c50m cycles (10 Hz); must be >= 2.
- SYNC_BYTE, 8'hA5, first byte of every packet.
- BUSY_TIMEOUT, 15, cycles to wait for tx_busy to rise after a transmit pulse; range 1..255.

Ports:
- c50m  in  1  system clock, 50 MHz
- rst_n  in  1  synchronous reset, active low
- period_en  in  1  1 enables the periodic tick
- req  in  4  one-cycle on-demand request per source, bit i = source i
- src_data  in  64  packed source data; source i on bits [16i+15:16i]
- ack  out  4  one-cycle pulse when the granted source's data is captured
- transmit  out  1  one-cycle pulse to the UART: load tx_byte
- tx_byte  out  8  byte presented to the UART
- tx_busy  in  1  UART is_transmitting
- busy  out  1  1 whenever state != IDLE
- frame_cnt  out  8  completed packets, wraps 255->0

Behaviour:
- Reset: one clock is c50m and reset is synchronous, active low. While rst_n=0 at a clock edge:
  - ack=0, transmit=0, tx_byte=0, busy=0, frame_cnt=0, pending=0.
  - Round-robin pointer = 0, tick counter = 0, state = IDLE.
- Reset mid-packet aborts immediately. No further transmit pulses; the partial packet is not completed.
- Tick:
  - The counter runs only while period_en=1. It counts 0..PERIOD_CYCLES-1.
  - At terminal count it wraps to 0 and sets all 4 pending bits.
  - period_en=0 holds the counter at its current value.
- Pending:
  - pending[i] is set by req[i] or a tick, and cleared by a grant of source i.
  - If set and clear occur in the same cycle, set wins.
  - Repeated requests while a bit is already pending merge into one packet.
- Arbitration:
  - In IDLE with pending!=0, grant the first pending source searching from pointer upward, mod 4.
  - On grant, in the same cycle:
    - capture the granted source's 16-bit data into a data register and pulse ack[granted];
    - pointer <= granted+1 mod 4;
    - go to SEND, byte index 0.
  - The grant decision is made one cycle after IDLE entry at the earliest.
- Packet bytes: SYNC_BYTE, {6'b0,id}, data[15:8], data[7:0], csum.
  - csum = (id + data[15:8] + data[7:0]) mod 256, where id is the 8-bit value {6'b0,id}. SYNC is excluded.
- States: IDLE, SEND, WAIT_HI, WAIT_LO.
  - SEND: if tx_busy=0, pulse transmit for exactly one cycle with tx_byte = byte[index], then go to WAIT_HI. If tx_busy=1, stall in SEND without pulsing.
  - WAIT_HI: wait for tx_busy=1, then go to WAIT_LO. If BUSY_TIMEOUT cycles pass without tx_busy=1, go directly to byte advance.
  - WAIT_LO: on tx_busy=0, do byte advance.
  - Byte advance: index 0..3 → index+1, go to SEND. Index 4 → frame_cnt+1, go to IDLE.
- tx_byte holds its value until the next transmit pulse.
- Transmit rules:
  - transmit is never asserted in two consecutive cycles.
  - transmit is never asserted outside SEND.
- Data captured at grant is used for the whole packet. Later src_data changes do not affect the packet in flight.
- Minimum packet time: 5 bytes × (UART byte time + 3 cycles overhead).

Test Plan:
- Single request: reset, then req=4'b0010 for 1 cycle with src_data[31:16]=16'h1234; UART model raises tx_busy 1 cycle after transmit, holds 10 cycles. Required: ack=4'b0010 once; bytes A5,01,12,34,47; frame_cnt=1; busy low afterwards.
- Round-robin: req=4'b1111 in one cycle. Required: packet IDs 0,1,2,3 in order; four ack pulses; frame_cnt=4. Then req=4'b1001. Required: ID 0 then ID 3, because pointer is 0.
- Tick: period_en=1, PERIOD_CYCLES=100, no req. Required: first tick at cycle 100 sets pending=4'hF; four packets follow. period_en=0 → no further packets.
- Busy timeout: UART model never raises tx_busy. Required: the next transmit comes exactly BUSY_TIMEOUT+2 cycles after the previous one; the packet completes.
- Collision and merge: req[2] pulsed 3 times during source 2's own packet, while source 2 is not pending. Required: exactly one extra ID-2 packet. Also a tick in the same cycle as a grant of source 1 leaves pending[1]=1.
- Reset mid-packet: rst_n=0 for 1 cycle after byte 2 is sent. Required: no further transmit; all outputs at reset values; a new req[0] produces a full 5-byte packet.

Source files
------------

// File: rtl/telemetry_tx_scheduler.sv
// Round-robin scheduler that frames four telemetry sources into 5-byte packets
// (SYNC, ID, DATA_HI, DATA_LO, CSUM) and feeds them byte by byte to one UART.
module telemetry_tx_scheduler #(
  parameter int unsigned PERIOD_CYCLES = 5000000,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned BUSY_TIMEOUT  = 15
) (
  input  logic        c50m,
  input  logic        rst_n,
  input  logic        period_en,
  input  logic [3:0]  req,
  input  logic [63:0] src_data,
  output logic [3:0]  ack,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  input  logic        tx_busy,
  output logic        busy,
  output logic [7:0]  frame_cnt
);

  localparam int CW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_e;

  state_e         state_q, state_d;
  logic [3:0]     pending_q, pending_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [CW-1:0]  tickCnt_q, tickCnt_d;
  logic [15:0]    data_q, data_d;
  logic [1:0]     id_q, id_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     timer_q, timer_d;
  logic [7:0]     txByte_q, txByte_d;
  logic [7:0]     frames_q, frames_d;

  logic           tickFire;
  logic           grantValid;
  logic [1:0]     grantId;
  logic [1:0]     cand;
  logic [3:0]     grantMask;
  logic           sendPulse;
  logic           advance;
  logic [7:0]     curByte;

  // Periodic tick: the counter freezes whenever period_en is low.
  always_comb begin
    tickFire  = period_en && (tickCnt_q == CW'(PERIOD_CYCLES - 1));
    tickCnt_d = tickCnt_q;
    if (period_en) begin
      tickCnt_d = tickFire ? '0 : tickCnt_q + CW'(1);
    end
  end

  // Scan downward so the source closest above the pointer wins.
  always_comb begin
    grantValid = 1'b0;
    grantId    = ptr_q;
    cand       = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (pending_q[cand]) begin
        grantValid = 1'b1;
        grantId    = cand;
      end
    end
  end

  always_comb begin
    case (idx_q)
      3'd0:    curByte = SYNC_BYTE;
      3'd1:    curByte = {6'b0, id_q};
      3'd2:    curByte = data_q[15:8];
      3'd3:    curByte = data_q[7:0];
      default: curByte = {6'b0, id_q} + data_q[15:8] + data_q[7:0];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    id_d      = id_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    txByte_d  = txByte_q;
    frames_d  = frames_q;
    grantMask = 4'b0;
    sendPulse = 1'b0;
    advance   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grantValid) begin
          grantMask = 4'b0001 << grantId;
          data_d    = src_data[{grantId, 4'b0000} +: 16];
          id_d      = grantId;
          ptr_d     = grantId + 2'd1;
          idx_d     = 3'd0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          sendPulse = 1'b1;
          txByte_d  = curByte;
          timer_d   = 8'd0;
          state_d   = WAIT_HI;
        end
      end
      WAIT_HI: begin
        // A UART that never signals busy still lets the packet finish.
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (timer_q == 8'(BUSY_TIMEOUT)) begin
          advance = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (idx_q == 3'd4) begin
        frames_d = frames_q + 8'd1;
        state_d  = IDLE;
      end else begin
        idx_d   = idx_q + 3'd1;
        state_d = SEND;
      end
    end

    // A new request or tick overrides a grant clear in the same cycle.
    pending_d = (pending_q & ~grantMask) | req | {4{tickFire}};
  end

  always_ff @(posedge c50m) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= 4'b0;
      ptr_q     <= 2'd0;
      tickCnt_q <= '0;
      data_q    <= 16'd0;
      id_q      <= 2'd0;
      idx_q     <= 3'd0;
      timer_q   <= 8'd0;
      txByte_q  <= 8'd0;
      frames_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      tickCnt_q <= tickCnt_d;
      data_q    <= data_d;
      id_q      <= id_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      txByte_q  <= txByte_d;
      frames_q  <= frames_d;
    end
  end

  assign ack       = rst_n ? grantMask : 4'b0;
  assign transmit  = rst_n & sendPulse;
  assign tx_byte   = transmit ? curByte : txByte_q;
  assign busy      = (state_q != IDLE);
  assign frame_cnt = frames_q;

endmodule
